// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like bus responder: word-addressed memory behind an in-order,
// fixed-latency response queue that bounds the number of outstanding requests.
module data_sram_like_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    input  logic        resp_hold,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW    = $clog2(OUTSTANDING + 1);
    localparam logic [2:0]    LAT      = 3'(LATENCY);
    localparam logic [CW-1:0] MAX_CNT  = CW'(OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);

    logic [31:0]   r_mem     [DEPTH];
    logic          r_q_wr    [OUTSTANDING];
    logic [31:0]   r_q_rdata [OUTSTANDING];
    logic [2:0]    r_q_age   [OUTSTANDING];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [DEPTH_LOG2-1:0] w_widx;
    logic                  w_push;
    logic                  w_pop;
    logic [PW-1:0]         w_head_nxt;
    logic [PW-1:0]         w_tail_nxt;
    logic                  w_unused;

    assign w_widx   = data_sram_addr[DEPTH_LOG2+1:2];
    assign w_unused = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};
    assign w_push   = data_sram_req && data_sram_addr_ok;
    assign w_pop    = data_sram_data_ok;

    // Handshake and response outputs; everything is forced low while reset is high.
    always_comb begin
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;
        if (!reset) begin
            data_sram_addr_ok = (r_count < MAX_CNT);
            data_sram_data_ok = (r_count != {CW{1'b0}}) && (r_q_age[r_head] == LAT) && !resp_hold;
            if (data_sram_data_ok && !r_q_wr[r_head]) begin
                data_sram_rdata = r_q_rdata[r_head];
            end else begin
                data_sram_rdata = 32'h0000_0000;
            end
        end else begin
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0000_0000;
        end
    end

    // Circular pointer increment, wrapping at the queue size.
    always_comb begin
        w_head_nxt = r_head + {{(PW-1){1'b0}}, 1'b1};
        w_tail_nxt = r_tail + {{(PW-1){1'b0}}, 1'b1};
        if (r_head == LAST_PTR) begin
            w_head_nxt = {PW{1'b0}};
        end else begin
            w_head_nxt = r_head + {{(PW-1){1'b0}}, 1'b1};
        end
        if (r_tail == LAST_PTR) begin
            w_tail_nxt = {PW{1'b0}};
        end else begin
            w_tail_nxt = r_tail + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Response queue: push on accept, pop on data_ok, per-entry saturating age.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_q_wr[i]    <= 1'b0;
                r_q_rdata[i] <= 32'h0000_0000;
                r_q_age[i]   <= 3'd0;
            end
        end else begin
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push) begin
                r_tail <= w_tail_nxt;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            for (int i = 0; i < OUTSTANDING; i++) begin
                // A new entry starts at 1: the accept edge itself counts toward the latency.
                if (w_push && (PW'(i) == r_tail)) begin
                    r_q_wr[i]    <= data_sram_wr;
                    r_q_rdata[i] <= data_sram_wr ? 32'h0000_0000 : r_mem[w_widx];
                    r_q_age[i]   <= 3'd1;
                end else if (r_q_age[i] < LAT) begin
                    r_q_age[i] <= r_q_age[i] + 3'd1;
                end
            end
        end
    end

    // Byte-enabled store into the memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_push && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
